// File: rtl/sense_sample_ctrl_pkg.sv
// Shared definitions for the sampler-domain sense sequencer.
package sense_sample_ctrl_pkg;

  localparam int unsigned CNT_W_DEF    = 8;
  localparam int unsigned SYNC_LAT_DEF = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_FLUSH  = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

endpackage

// File: rtl/sense_dwell_cnt.sv
// Loadable down-counter shared by the settle, flush and sample phases.
// A phase loaded with N-1 lasts N cycles; o_zero_c marks its last cycle.
module sense_dwell_cnt
  import sense_sample_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_en,
  output logic             o_zero_c
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_zero_c = (r_cnt == '0);

endmodule

// File: rtl/sense_sample_ctrl.sv
// Sense-path sequencer: enable front end, settle, flush synchronizer,
// count ones over num_samples cycles and report a strict-majority decision.
module sense_sample_ctrl
  import sense_sample_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W    = CNT_W_DEF,
  parameter int unsigned SYNC_LAT = SYNC_LAT_DEF
) (
  input  logic             clk_sampler,
  input  logic             rst_sampler,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] settle_cycles,
  input  logic [CNT_W-1:0] num_samples,
  input  logic             sense_in_sync,
  output logic             sense_en,
  output logic             busy,
  output logic             result_valid,
  output logic             result_bit,
  output logic [CNT_W-1:0] ones_count,
  output logic             cfg_err
);

  localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(SYNC_LAT - 1);

  state_e           r_state;
  logic [CNT_W-1:0] r_num;
  logic [CNT_W-1:0] r_acc;
  logic [CNT_W-1:0] r_ones_count;
  logic             r_sense_en;
  logic             r_busy;
  logic             r_result_valid;
  logic             r_result_bit;
  logic             r_cfg_err;

  logic             w_start_ok;
  logic             w_load;
  logic [CNT_W-1:0] w_load_val;
  logic             w_cnt_en;
  logic             w_cnt_zero;
  logic [CNT_W-1:0] w_ones_next;

  assign w_start_ok  = start && !abort && (num_samples != '0);
  assign w_ones_next = r_acc + CNT_W'(sense_in_sync);

  // Counter control: each phase preloads the next phase's length minus one.
  always_comb begin
    w_load     = 1'b0;
    w_load_val = '0;
    w_cnt_en   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start_ok) begin
          w_load     = 1'b1;
          w_load_val = (settle_cycles == '0) ? FLUSH_LOAD : settle_cycles - CNT_W'(1);
        end
      end
      ST_SETTLE: begin
        if (w_cnt_zero) begin
          w_load     = 1'b1;
          w_load_val = FLUSH_LOAD;
        end else begin
          w_cnt_en = 1'b1;
        end
      end
      ST_FLUSH: begin
        if (w_cnt_zero) begin
          w_load     = 1'b1;
          w_load_val = r_num - CNT_W'(1);
        end else begin
          w_cnt_en = 1'b1;
        end
      end
      ST_SAMPLE: w_cnt_en = 1'b1;
      default:   w_cnt_en = 1'b0;
    endcase
  end

  sense_dwell_cnt #(.CNT_W(CNT_W)) u_dwell (
    .i_clk      (clk_sampler),
    .i_rst      (rst_sampler),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_en       (w_cnt_en),
    .o_zero_c   (w_cnt_zero)
  );

  always_ff @(posedge clk_sampler or posedge rst_sampler) begin
    if (rst_sampler) begin
      r_state        <= ST_IDLE;
      r_num          <= '0;
      r_acc          <= '0;
      r_ones_count   <= '0;
      r_sense_en     <= 1'b0;
      r_busy         <= 1'b0;
      r_result_valid <= 1'b0;
      r_result_bit   <= 1'b0;
      r_cfg_err      <= 1'b0;
    end else begin
      r_result_valid <= 1'b0;
      r_cfg_err      <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start && !abort) begin
            if (num_samples == '0) begin
              r_cfg_err <= 1'b1;
            end else begin
              r_num      <= num_samples;
              r_acc      <= '0;
              r_sense_en <= 1'b1;
              r_busy     <= 1'b1;
              r_state    <= (settle_cycles == '0) ? ST_FLUSH : ST_SETTLE;
            end
          end
        end
        ST_SETTLE: begin
          if (abort) begin
            r_state    <= ST_IDLE;
            r_sense_en <= 1'b0;
            r_busy     <= 1'b0;
          end else if (w_cnt_zero) begin
            r_state <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (abort) begin
            r_state    <= ST_IDLE;
            r_sense_en <= 1'b0;
            r_busy     <= 1'b0;
          end else if (w_cnt_zero) begin
            r_state <= ST_SAMPLE;
          end
        end
        ST_SAMPLE: begin
          if (abort) begin
            r_state    <= ST_IDLE;
            r_sense_en <= 1'b0;
            r_busy     <= 1'b0;
          end else begin
            r_acc <= w_ones_next;
            // Last sample: publish in the same edge so results appear in DONE.
            if (w_cnt_zero) begin
              r_ones_count   <= w_ones_next;
              r_result_bit   <= ({w_ones_next, 1'b0} > {1'b0, r_num});
              r_result_valid <= 1'b1;
              r_sense_en     <= 1'b0;
              r_state        <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state    <= ST_IDLE;
          r_sense_en <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign sense_en     = r_sense_en;
  assign busy         = r_busy;
  assign result_valid = r_result_valid;
  assign result_bit   = r_result_bit;
  assign ones_count   = r_ones_count;
  assign cfg_err      = r_cfg_err;

endmodule

// File: tb/tb_sense_sample_ctrl.sv
// Randomized bench for sense_sample_ctrl against a timeline-level reference model.
module tb_sense_sample_ctrl;

  localparam int CNT_W    = 8;
  localparam int SYNC_LAT = 2;

  logic             clk_sampler = 1'b0;
  logic             rst_sampler;
  logic             start;
  logic             abort;
  logic [CNT_W-1:0] settle_cycles;
  logic [CNT_W-1:0] num_samples;
  logic             sense_in_sync;
  logic             sense_en;
  logic             busy;
  logic             result_valid;
  logic             result_bit;
  logic [CNT_W-1:0] ones_count;
  logic             cfg_err;

  int checks   = 0;
  int failures = 0;

  logic [CNT_W-1:0] hold_ones;
  logic             hold_bit;

  sense_sample_ctrl #(.CNT_W(CNT_W), .SYNC_LAT(SYNC_LAT)) dut (
    .clk_sampler   (clk_sampler),
    .rst_sampler   (rst_sampler),
    .start         (start),
    .abort         (abort),
    .settle_cycles (settle_cycles),
    .num_samples   (num_samples),
    .sense_in_sync (sense_in_sync),
    .sense_en      (sense_en),
    .busy          (busy),
    .result_valid  (result_valid),
    .result_bit    (result_bit),
    .ones_count    (ones_count),
    .cfg_err       (cfg_err)
  );

  always #5 clk_sampler = ~clk_sampler;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_sampler);
    #1;
  endtask

  // One measurement. abort_at: cycle index (0 = start cycle) to pulse abort, -1 for none.
  // mode: 0 random sense, 1 all ones, 2 window pattern 1,1,0,0,...
  task automatic run_meas(input string tag, input int settle, input int num,
                          input int abort_at, input int mode);
    int w0;
    int lat;
    int exp_en;
    int ones_in;
    int en_cnt;
    int rv_cnt;
    int rv_at;
    int busy_bad;
    bit idle_abort;
    bit aborted;
    bit normal;
    bit s;
    bit exp_busy;
    logic [CNT_W-1:0] got_ones;
    logic             got_bit;
    w0         = settle + SYNC_LAT + 1;
    lat        = w0 + num;
    idle_abort = (abort_at == 0);
    aborted    = (abort_at >= 1) && (abort_at < lat);
    normal     = !idle_abort && !aborted;
    exp_en     = idle_abort ? 0 : (aborted ? abort_at : lat - 1);
    ones_in = 0; en_cnt = 0; rv_cnt = 0; rv_at = -1; busy_bad = 0;
    got_ones = '0; got_bit = 1'b0;

    step();
    start         = 1'b1;
    settle_cycles = CNT_W'(settle);
    num_samples   = CNT_W'(num);
    for (int k = 0; k <= lat + 2; k++) begin
      if (k > 0) begin
        step();
        start = 1'b0;
      end
      abort = (k == abort_at);
      if (k == 1) begin
        settle_cycles = CNT_W'($urandom);
        num_samples   = CNT_W'($urandom_range(1, 255));
      end
      if (abort_at < 0 && k == w0) begin
        start         = 1'b1;
        num_samples   = CNT_W'(200);
        settle_cycles = '0;
      end
      if (mode == 1)      s = 1'b1;
      else if (mode == 2) s = ((k - w0) < 2);
      else                s = 1'($urandom_range(0, 1));
      sense_in_sync = s;
      if (k >= w0 && k < w0 + num) ones_in += int'(s);
      @(negedge clk_sampler);
      if (idle_abort)   exp_busy = 1'b0;
      else if (aborted) exp_busy = (k >= 1) && (k <= abort_at);
      else              exp_busy = (k >= 1) && (k <= lat);
      if (busy !== exp_busy) busy_bad++;
      if (sense_en) en_cnt++;
      if (result_valid) begin
        rv_cnt++;
        rv_at    = k;
        got_ones = ones_count;
        got_bit  = result_bit;
      end
    end
    start = 1'b0;
    abort = 1'b0;

    if (normal) begin
      hold_ones = CNT_W'(ones_in);
      hold_bit  = (2 * ones_in > num);
    end
    check_eq({tag, ".sense_en_cycles"}, en_cnt, exp_en);
    check_eq({tag, ".valid_pulses"}, rv_cnt, normal ? 1 : 0);
    check_eq({tag, ".busy_profile_errs"}, busy_bad, 0);
    if (normal) begin
      check_eq({tag, ".latency"}, rv_at, lat);
      check_eq({tag, ".ones_at_valid"}, got_ones, ones_in);
      check_eq({tag, ".bit_at_valid"}, got_bit, hold_bit);
    end
    check_eq({tag, ".ones_held"}, ones_count, hold_ones);
    check_eq({tag, ".bit_held"}, result_bit, hold_bit);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int settle;
    int num;
    int ab;
    rst_sampler   = 1'b1;
    start         = 1'b0;
    abort         = 1'b0;
    settle_cycles = '0;
    num_samples   = '0;
    sense_in_sync = 1'b0;
    hold_ones     = '0;
    hold_bit      = 1'b0;
    #3;
    check_eq("reset.outputs", {sense_en, busy, result_valid, result_bit, cfg_err, ones_count}, 0);
    @(negedge clk_sampler);
    rst_sampler = 1'b0;

    run_meas("s3n5_ones", 3, 5, -1, 1);
    run_meas("s0n4_tie", 0, 4, -1, 2);

    // Zero sample count is rejected.
    step();
    start = 1'b1; num_samples = '0; settle_cycles = CNT_W'(3);
    step();
    start = 1'b0;
    @(negedge clk_sampler);
    check_eq("cfgerr.pulse", cfg_err, 1);
    check_eq("cfgerr.busy_en", {busy, sense_en}, 0);
    step();
    @(negedge clk_sampler);
    check_eq("cfgerr.one_cycle", {cfg_err, busy, sense_en}, 0);

    run_meas("s10n8_abort5", 10, 8, 5, 0);
    run_meas("start_abort_idle", 2, 3, 0, 0);
    run_meas("n3_restart_ignored", 1, 3, -1, 1);

    // Asynchronous reset in the middle of SAMPLE.
    step();
    start = 1'b1; settle_cycles = CNT_W'(2); num_samples = CNT_W'(50);
    step();
    start = 1'b0;
    repeat (8) step();
    @(negedge clk_sampler);
    check_eq("rstmid.busy_before", {busy, sense_en}, 3);
    #2;
    rst_sampler = 1'b1;
    #1;
    check_eq("rstmid.outputs_async", {sense_en, busy, result_valid, result_bit, cfg_err, ones_count}, 0);
    @(negedge clk_sampler);
    rst_sampler = 1'b0;
    hold_ones   = '0;
    hold_bit    = 1'b0;

    run_meas("n255_ones", 1, 255, -1, 1);

    for (int i = 0; i < 24; i++) begin
      settle = $urandom_range(0, 6);
      num    = $urandom_range(1, 12);
      ab     = ($urandom_range(0, 3) == 0) ? $urandom_range(0, settle + SYNC_LAT + 1 + num) : -1;
      run_meas($sformatf("rand%0d", i), settle, num, ab, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
